uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one `Uart8` transmitter between `NUM_REQ` byte producers. It grants one requester at a time, latches that requester's byte, and drives the UART's `txEn`/`txStart`/`txIn`. It watches `txBusy`/`txDone` and returns a one-cycle `ack` to the owner when its byte has left the line. It sits between the board's message sources and the `Uart8` tx interface, in the same clock domain.

---
 rtl/uart_tx_arbiter.sv | 133 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one Uart8 transmitter between NUM_REQ byte producers.
// One owner at a time: latch its byte, drive txEn/txStart/txIn, ack once txDone is seen.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 4096
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [8*NUM_REQ-1:0]       reqByte_i,
    output logic [NUM_REQ-1:0]         ack_o,
    output logic [$clog2(NUM_REQ)-1:0] grantId_o,
    output logic                       active_o,
    output logic                       err_o,
    output logic                       txEn_o,
    output logic                       txStart_o,
    output logic [7:0]                 txIn_o,
    input  logic                       txBusy_i,
    input  logic                       txDone_i
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(START_TIMEOUT + 1);
    localparam logic [IW-1:0]      LAST_ID   = IW'(NUM_REQ - 1);
    localparam logic [CW-1:0]      CNT_LIMIT = CW'(START_TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT   = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, START, SEND, DONE} state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [IW-1:0]      grantId_q;
    logic [IW-1:0]      lastGrant_q;
    logic [CW-1:0]      count_q;
    logic [7:0]         txIn_q;
    logic               active_q;
    logic               err_q;
    logic               txEn_q;
    logic               txStart_q;

    logic               hit_d;
    logic [IW-1:0]      winner_d;
    logic [7:0]         winByte_d;

    // First pending request strictly after the previous owner, wrapping at NUM_REQ-1.
    always_comb begin
        logic [IW-1:0] idx;
        hit_d     = 1'b0;
        winner_d  = '0;
        winByte_d = '0;
        idx       = lastGrant_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (idx == LAST_ID) ? '0 : idx + IW'(1);
            if (!hit_d && req_i[idx]) begin
                hit_d    = 1'b1;
                winner_d = idx;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (winner_d == IW'(j)) begin
                winByte_d = reqByte_i[8*j +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            ack_q       <= '0;
            grantId_q   <= '0;
            lastGrant_q <= LAST_ID;
            count_q     <= '0;
            txIn_q      <= 8'h00;
            active_q    <= 1'b0;
            err_q       <= 1'b0;
            txEn_q      <= 1'b0;
            txStart_q   <= 1'b0;
        end else begin
            ack_q <= '0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Any txBusy/txDone activity here belongs to nobody, so it only blocks grants.
                    if (hit_d && !txBusy_i && !txDone_i) begin
                        state_q   <= START;
                        txIn_q    <= winByte_d;
                        grantId_q <= winner_d;
                        count_q   <= '0;
                        txEn_q    <= 1'b1;
                        txStart_q <= 1'b1;
                        active_q  <= 1'b1;
                    end
                end
                START: begin
                    if (count_q != '1) begin
                        count_q <= count_q + CW'(1);
                    end
                    if (txBusy_i) begin
                        state_q   <= SEND;
                        txStart_q <= 1'b0;
                    end else if (count_q == CNT_LIMIT) begin
                        state_q     <= IDLE;
                        err_q       <= 1'b1;
                        lastGrant_q <= grantId_q;
                        txEn_q      <= 1'b0;
                        txStart_q   <= 1'b0;
                        active_q    <= 1'b0;
                    end
                end
                SEND: begin
                    if (txDone_i) begin
                        state_q  <= DONE;
                        active_q <= 1'b0;
                        ack_q    <= ONE_HOT << grantId_q;
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    lastGrant_q <= grantId_q;
                    txEn_q      <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_o     = ack_q;
    assign grantId_o = grantId_q;
    assign active_o  = active_q;
    assign err_o     = err_q;
    assign txEn_o    = txEn_q;
    assign txStart_o = txStart_q;
    assign txIn_o    = txIn_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a stand-in Uart8 responder plus a cycle model of the arbiter rules.
// Directed scenarios pin the model with literal expectations on ack order and sent bytes.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int TIMEOUT  = 16;
    localparam int BUSY_LEN = 3;

    logic                 clock   = 1'b0;
    logic                 reset   = 1'b1;
    logic [NUM_REQ-1:0]   req     = '0;
    logic [8*NUM_REQ-1:0] reqByte = '0;
    logic                 txBusy  = 1'b0;
    logic                 txDone  = 1'b0;
    logic [NUM_REQ-1:0]   ack;
    logic [1:0]           grantId;
    logic                 active;
    logic                 err;
    logic                 txEn;
    logic                 txStart;
    logic [7:0]           txIn;

    int compared   = 0;
    int mismatched = 0;

    int          rState = 0;
    int          rCnt   = 0;
    bit          respOn = 1'b1;
    logic [7:0]  rxLog[$];
    int          ackOrder[$];
    int          errCount = 0;

    logic                 pReset  = 1'b1;
    logic [NUM_REQ-1:0]   pReq    = '0;
    logic [8*NUM_REQ-1:0] pBytes  = '0;
    logic                 pBusy   = 1'b0;
    logic                 pDone   = 1'b0;
    int                   mPhase  = 0;
    int                   mGrant  = 0;
    int                   mLast   = NUM_REQ - 1;
    int                   mStart  = 0;
    logic [7:0]           mByte   = 8'h00;
    bit                   mErr    = 1'b0;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .START_TIMEOUT(TIMEOUT)) dut (
        .clk_i(clock), .reset_i(reset), .req_i(req), .reqByte_i(reqByte),
        .ack_o(ack), .grantId_o(grantId), .active_o(active), .err_o(err),
        .txEn_o(txEn), .txStart_o(txStart), .txIn_o(txIn),
        .txBusy_i(txBusy), .txDone_i(txDone)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic int nextOwner(input logic [NUM_REQ-1:0] r, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return 0;
    endfunction

    // One clock: the responder reacts like Uart8 (busy for BUSY_LEN cycles, then a done pulse).
    task automatic tick();
        @(posedge clock);
        #1;
        if (reset) begin
            rState = 0;
            rCnt   = 0;
            txBusy = 1'b0;
            txDone = 1'b0;
        end else begin
            case (rState)
                0: if (respOn && txEn && txStart) begin
                    rxLog.push_back(txIn);
                    txBusy = 1'b1;
                    rCnt   = BUSY_LEN;
                    rState = 1;
                end
                1: if (rCnt > 1) rCnt--;
                   else begin
                       txBusy = 1'b0;
                       txDone = 1'b1;
                       rState = 2;
                   end
                default: begin
                    txDone = 1'b0;
                    rState = 0;
                end
            endcase
        end
        req = req & ~ack;
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] reqV, input logic [8*NUM_REQ-1:0] bytes);
        reqByte = bytes;
        req     = reqV;
    endtask

    task automatic runUntilClear(input int budget);
        int n = 0;
        while (req != '0 && n < budget) begin
            tick();
            n++;
        end
        compared++;
        if (req != '0) begin
            mismatched++;
            $display("[TB] FAIL wait for acks: req still %b after %0d cycles, required 0", req, budget);
        end
        repeat (2) tick();
    endtask

    // Spec-level cycle model, advanced from the inputs the DUT sampled at the previous edge.
    initial begin
        forever begin
            @(negedge clock);
            mErr = 1'b0;
            if (pReset) begin
                mPhase = 0;
                mLast  = NUM_REQ - 1;
                mGrant = 0;
                mByte  = 8'h00;
            end else begin
                case (mPhase)
                    0: if (pReq != '0 && !pBusy && !pDone) begin
                        mGrant = nextOwner(pReq, mLast);
                        mByte  = pBytes[8*mGrant +: 8];
                        mStart = 0;
                        mPhase = 1;
                    end
                    1: begin
                        mStart++;
                        if (pBusy) mPhase = 2;
                        else if (mStart == TIMEOUT) begin
                            mErr   = 1'b1;
                            mLast  = mGrant;
                            mPhase = 0;
                        end
                    end
                    2: if (pDone) mPhase = 3;
                    default: begin
                        mLast  = mGrant;
                        mPhase = 0;
                    end
                endcase
            end
            checkOutput("txEn", txEn, mPhase != 0);
            checkOutput("txStart", txStart, mPhase == 1);
            checkOutput("active", active, mPhase == 1 || mPhase == 2);
            checkOutput("ack", ack, (mPhase == 3) ? (32'd1 << mGrant) : 32'd0);
            checkOutput("err", err, mErr);
            checkOutput("grantId", grantId, mGrant);
            checkOutput("txIn", txIn, mByte);
            for (int k = 0; k < NUM_REQ; k++) begin
                if (ack[k]) ackOrder.push_back(k);
            end
            if (err) errCount++;
            pReset = reset;
            pReq   = req;
            pBytes = reqByte;
            pBusy  = txBusy;
            pDone  = txDone;
        end
    end

    initial begin
        int errSnap;
        repeat (3) tick();
        checkOutput("reset grantId", grantId, 0);
        checkOutput("reset txIn", txIn, 8'h00);
        checkOutput("reset txEn/txStart/active", {txEn, txStart, active}, 3'b000);
        reset = 1'b0;

        applyStimulus(4'b1111, {8'h43, 8'h32, 8'h21, 8'h10});
        runUntilClear(300);
        checkOutput("simultaneous ack count", ackOrder.size(), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("simultaneous ack order", (i < ackOrder.size()) ? ackOrder[i] : -1, i);
            checkOutput("simultaneous byte order", (i < rxLog.size()) ? rxLog[i] : 8'hxx, 8'h10 + 8'h11 * i);
        end

        ackOrder.delete(); rxLog.delete();
        applyStimulus(4'b0100, {8'h00, 8'h7A, 8'h00, 8'h00});
        runUntilClear(100);
        checkOutput("single ack count", ackOrder.size(), 1);
        checkOutput("single ack owner", (ackOrder.size() > 0) ? ackOrder[0] : -1, 2);
        checkOutput("single byte", (rxLog.size() > 0) ? rxLog[0] : 8'hxx, 8'h7A);
        checkOutput("single active after", active, 1'b0);

        applyStimulus(4'b0010, {8'h00, 8'h00, 8'h5A, 8'h00});
        runUntilClear(100);
        ackOrder.delete(); rxLog.delete();
        applyStimulus(4'b1001, {8'hD3, 8'h00, 8'h00, 8'hD0});
        runUntilClear(200);
        checkOutput("fairness first", (ackOrder.size() > 0) ? ackOrder[0] : -1, 3);
        checkOutput("fairness second", (ackOrder.size() > 1) ? ackOrder[1] : -1, 0);

        rxLog.delete();
        applyStimulus(4'b0001, {8'h00, 8'h00, 8'h00, 8'h7A});
        tick();
        checkOutput("latch grant txStart", txStart, 1'b1);
        reqByte[7:0] = 8'hB1;
        runUntilClear(100);
        req = 4'b0001;
        runUntilClear(100);
        checkOutput("latch first byte", (rxLog.size() > 0) ? rxLog[0] : 8'hxx, 8'h7A);
        checkOutput("latch second byte", (rxLog.size() > 1) ? rxLog[1] : 8'hxx, 8'hB1);

        rxLog.delete();
        txBusy = 1'b1;
        applyStimulus(4'b0001, {8'h00, 8'h00, 8'h00, 8'h5C});
        repeat (4) tick();
        checkOutput("busy blocks grant", active, 1'b0);
        txBusy = 1'b0;
        runUntilClear(100);
        checkOutput("after busy byte", (rxLog.size() > 0) ? rxLog[0] : 8'hxx, 8'h5C);

        ackOrder.delete(); rxLog.delete();
        errSnap = errCount;
        respOn = 1'b0;
        applyStimulus(4'b0100, {8'h00, 8'h55, 8'h00, 8'h00});
        repeat (20) tick();
        checkOutput("timeout err pulses", errCount - errSnap, 1);
        checkOutput("timeout no ack", ackOrder.size(), 0);
        checkOutput("timeout retried", txStart, 1'b1);
        respOn = 1'b1;
        runUntilClear(100);
        checkOutput("timeout retry byte", (rxLog.size() > 0) ? rxLog[0] : 8'hxx, 8'h55);
        checkOutput("timeout retry ack", (ackOrder.size() > 0) ? ackOrder[0] : -1, 2);

        ackOrder.delete(); rxLog.delete();
        applyStimulus(4'b1000, {8'hC3, 8'h00, 8'h00, 8'h00});
        repeat (2) tick();
        checkOutput("pre-reset SEND", {active, txStart}, 2'b10);
        reset = 1'b1;
        tick();
        checkOutput("mid reset outputs", {ack, active, err, txEn, txStart}, 9'b0);
        checkOutput("mid reset txIn", txIn, 8'h00);
        checkOutput("mid reset grantId", grantId, 0);
        reset = 1'b0;
        runUntilClear(100);
        checkOutput("reset retry ack count", ackOrder.size(), 1);
        checkOutput("reset retry owner", (ackOrder.size() > 0) ? ackOrder[0] : -1, 3);
        checkOutput("reset retry byte", (rxLog.size() > 1) ? rxLog[1] : 8'hxx, 8'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
